// File: rtl/ctrl_seq_pkg.sv
// Shared opcode, funct5, alu_op and amo_phase encodings, the sequencer state enum,
// and the registered control word handed to execute.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;

  localparam logic [4:0] F5_LR = 5'b00010;
  localparam logic [4:0] F5_SC = 5'b00011;

  localparam logic [2:0] ALU_MEM = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_OP  = 3'b010;
  localparam logic [2:0] ALU_JMP = 3'b011;
  localparam logic [2:0] ALU_AMO = 3'b100;
  localparam logic [2:0] ALU_IMM = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  localparam logic [1:0] PH_NONE = 2'b00;
  localparam logic [1:0] PH_RD   = 2'b01;
  localparam logic [1:0] PH_WR   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_AMO_RD, ST_AMO_WR} state_t;

  typedef struct packed {
    logic       vld;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
    logic [1:0] amo_phase;
    logic       sc_fail;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-in / control-word-out handshake bundle; master drives instructions,
// slave (the sequencer) returns ready and the registered control word.
interface ctrl_seq_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] mem_addr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              branch;
  logic              mem_read;
  logic              mem_to_reg;
  logic              mem_write;
  logic              alu_src;
  logic              reg_write;
  logic [2:0]        alu_op;
  logic [1:0]        amo_phase;
  logic              sc_fail;
  logic              illegal;

  modport master (
    output in_valid, instruction, mem_addr, flush, out_ready,
    input  in_ready, out_valid, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_op, amo_phase, sc_fail, illegal
  );

  modport slave (
    input  in_valid, instruction, mem_addr, flush, out_ready,
    output in_ready, out_valid, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_op, amo_phase, sc_fail, illegal
  );
endinterface

// File: rtl/ctrl_seq_decode.sv
// Combinational opcode-class decoder; AMO opcodes only get alu_op here, the
// sequencer fills in the phase-dependent bits.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output ctrl_word_t o_word
);

  always_comb begin
    o_word     = '0;
    o_word.vld = 1'b1;
    case (i_opcode)
      OPC_LOAD: begin
        o_word.mem_read   = 1'b1;
        o_word.mem_to_reg = 1'b1;
        o_word.reg_write  = 1'b1;
        o_word.alu_src    = 1'b1;
        o_word.alu_op     = ALU_MEM;
      end
      OPC_STORE: begin
        o_word.mem_write = 1'b1;
        o_word.alu_src   = 1'b1;
        o_word.alu_op    = ALU_MEM;
      end
      OPC_BRANCH: begin
        o_word.branch = 1'b1;
        o_word.alu_op = ALU_BR;
      end
      OPC_OP: begin
        o_word.reg_write = 1'b1;
        o_word.alu_op    = ALU_OP;
      end
      OPC_OP_IMM: begin
        o_word.reg_write = 1'b1;
        o_word.alu_src   = 1'b1;
        o_word.alu_op    = ALU_IMM;
      end
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
        o_word.reg_write = 1'b1;
        o_word.alu_src   = 1'b1;
        o_word.alu_op    = ALU_JMP;
      end
      OPC_AMO: o_word.alu_op = ALU_AMO;
      default: begin
        o_word.alu_op  = ALU_ILL;
        o_word.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Registered control sequencer: one-cycle accept-to-word latency, AMOs split into
// read/write phases, LR/SC reservation; in_ready drops while a word is stuck or an AMO runs.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int GRAIN_LSB = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_seq_if.slave  io_bus
);

  localparam int GW = ADDR_W - GRAIN_LSB;

  state_t         r_state, w_state_nxt;
  ctrl_word_t     r_word, w_word_nxt, w_dec;
  logic           r_rsv_vld, w_rsv_vld_nxt;
  logic [GW-1:0]  r_rsv_gran, w_rsv_gran_nxt, w_gran;
  logic [6:0]     w_opcode;
  logic [4:0]     w_funct5;
  logic           w_accept, w_match, w_unused;

  assign w_opcode = io_bus.instruction[6:0];
  assign w_funct5 = io_bus.instruction[31:27];
  assign w_gran   = io_bus.mem_addr[ADDR_W-1:GRAIN_LSB];
  assign w_unused = ^{io_bus.instruction[26:7], io_bus.mem_addr[GRAIN_LSB-1:0]};

  // Reservation is judged on its registered value, i.e. as it stood at cycle start.
  assign w_match = r_rsv_vld && (r_rsv_gran == w_gran);

  assign io_bus.in_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && io_bus.out_ready);
  assign w_accept        = io_bus.in_valid && io_bus.in_ready && !io_bus.flush;

  ctrl_decode u_decode (.i_opcode(w_opcode), .o_word(w_dec));

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_rsv_vld_nxt  = r_rsv_vld;
    w_rsv_gran_nxt = r_rsv_gran;
    if (io_bus.flush) begin
      w_state_nxt   = ST_IDLE;
      w_word_nxt    = '0;
      w_rsv_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD, ST_AMO_WR: begin
          if (io_bus.out_ready) begin
            w_state_nxt = ST_IDLE;
            w_word_nxt  = '0;
          end
        end
        ST_AMO_RD: begin
          if (io_bus.out_ready) begin
            w_state_nxt          = ST_AMO_WR;
            w_word_nxt           = '0;
            w_word_nxt.vld       = 1'b1;
            w_word_nxt.mem_write = 1'b1;
            w_word_nxt.alu_src   = 1'b1;
            w_word_nxt.alu_op    = ALU_AMO;
            w_word_nxt.amo_phase = PH_WR;
          end
        end
        default: ;
      endcase
      if (w_accept) begin
        w_state_nxt = ST_HOLD;
        w_word_nxt  = w_dec;
        if (w_opcode == OPC_AMO) begin
          if (w_funct5 == F5_SC) begin
            w_rsv_vld_nxt        = 1'b0;
            w_word_nxt.reg_write = 1'b1;
            if (w_match) begin
              w_word_nxt.mem_write = 1'b1;
              w_word_nxt.alu_src   = 1'b1;
              w_word_nxt.amo_phase = PH_WR;
            end else begin
              w_word_nxt.sc_fail = 1'b1;
            end
          end else begin
            // LR and the read phase of a full AMO share the same load-like bits.
            w_word_nxt.mem_read   = 1'b1;
            w_word_nxt.mem_to_reg = 1'b1;
            w_word_nxt.reg_write  = 1'b1;
            w_word_nxt.alu_src    = 1'b1;
            w_word_nxt.amo_phase  = PH_RD;
            if (w_funct5 == F5_LR) begin
              w_rsv_vld_nxt  = 1'b1;
              w_rsv_gran_nxt = w_gran;
            end else begin
              w_state_nxt = ST_AMO_RD;
              if (w_match) w_rsv_vld_nxt = 1'b0;
            end
          end
        end else if ((w_opcode == OPC_STORE) && w_match) begin
          w_rsv_vld_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_rsv_vld  <= 1'b0;
      r_rsv_gran <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_rsv_vld  <= w_rsv_vld_nxt;
      r_rsv_gran <= w_rsv_gran_nxt;
    end
  end

  assign io_bus.out_valid  = r_word.vld;
  assign io_bus.branch     = r_word.branch;
  assign io_bus.mem_read   = r_word.mem_read;
  assign io_bus.mem_to_reg = r_word.mem_to_reg;
  assign io_bus.mem_write  = r_word.mem_write;
  assign io_bus.alu_src    = r_word.alu_src;
  assign io_bus.reg_write  = r_word.reg_write;
  assign io_bus.alu_op     = r_word.alu_op;
  assign io_bus.amo_phase  = r_word.amo_phase;
  assign io_bus.sc_fail    = r_word.sc_fail;
  assign io_bus.illegal    = r_word.illegal;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: the stimulus side pushes expected words from a
// transaction-level model, a negedge monitor checks and pops them.
module tb_ctrl_seq;

  localparam int ADDR_W    = 32;
  localparam int GRAIN_LSB = 2;
  localparam int GW        = ADDR_W - GRAIN_LSB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq_if #(.ADDR_W(ADDR_W)) bus ();

  ctrl_seq #(.ADDR_W(ADDR_W), .GRAIN_LSB(GRAIN_LSB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic [12:0] w;
    bit          multi;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  bit            rsv_v  = 1'b0;
  logic [GW-1:0] rsv_g  = '0;
  logic          exp_ir;

  logic [6:0] opc_tab [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                               7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111,
                               7'b0010111, 7'b0101111, 7'b0101111, 7'b1111111};
  logic [4:0] f5_tab  [7]  = '{5'b00010, 5'b00011, 5'b00000, 5'b00001, 5'b01100,
                               5'b00010, 5'b00011};

  // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, amo_phase, sc_fail, illegal}
  function automatic logic [12:0] mk(input bit br, input bit mr, input bit mtr, input bit mw,
                                     input bit as, input bit rw, input logic [2:0] aop,
                                     input logic [1:0] ph, input bit scf, input bit ill);
    return {br, mr, mtr, mw, as, rw, aop, ph, scf, ill};
  endfunction

  function automatic logic [12:0] dut_word();
    return {bus.branch, bus.mem_read, bus.mem_to_reg, bus.mem_write, bus.alu_src,
            bus.reg_write, bus.alu_op, bus.amo_phase, bus.sc_fail, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [6:0] opc, input logic [4:0] f5);
    return {f5, 2'b00, 5'd2, 5'd1, 3'b010, 5'd3, opc};
  endfunction

  // Reference model: what execute should see for one accepted instruction.
  task automatic model_accept(input logic [31:0] ins, input logic [ADDR_W-1:0] a);
    logic [6:0]    op;
    logic [4:0]    f5;
    logic [GW-1:0] g;
    bit            m;
    exp_t          e;
    op      = ins[6:0];
    f5      = ins[31:27];
    g       = a[ADDR_W-1:GRAIN_LSB];
    m       = rsv_v && (rsv_g == g);
    e.multi = 1'b0;
    case (op)
      7'b0000011: e.w = mk(0, 1, 1, 0, 1, 1, 3'b000, 2'b00, 0, 0);
      7'b0100011: begin
        e.w = mk(0, 0, 0, 1, 1, 0, 3'b000, 2'b00, 0, 0);
        if (m) rsv_v = 1'b0;
      end
      7'b1100011: e.w = mk(1, 0, 0, 0, 0, 0, 3'b001, 2'b00, 0, 0);
      7'b0110011: e.w = mk(0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 0, 0);
      7'b0010011: e.w = mk(0, 0, 0, 0, 1, 1, 3'b110, 2'b00, 0, 0);
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
                  e.w = mk(0, 0, 0, 0, 1, 1, 3'b011, 2'b00, 0, 0);
      7'b0101111: begin
        if (f5 == 5'b00010) begin
          e.w   = mk(0, 1, 1, 0, 1, 1, 3'b100, 2'b01, 0, 0);
          rsv_v = 1'b1;
          rsv_g = g;
        end else if (f5 == 5'b00011) begin
          e.w   = m ? mk(0, 0, 0, 1, 1, 1, 3'b100, 2'b10, 0, 0)
                    : mk(0, 0, 0, 0, 0, 1, 3'b100, 2'b00, 1, 0);
          rsv_v = 1'b0;
        end else begin
          e.multi = 1'b1;
          e.w     = mk(0, 1, 1, 0, 1, 1, 3'b100, 2'b01, 0, 0);
          q.push_back(e);
          e.w     = mk(0, 0, 0, 1, 1, 0, 3'b100, 2'b10, 0, 0);
          if (m) rsv_v = 1'b0;
        end
      end
      default: e.w = mk(0, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0, 1);
    endcase
    q.push_back(e);
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [ADDR_W-1:0] a,
                      input bit fl, input bit ordy, output bit acc);
    @(posedge clk);
    #1;
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.mem_addr    = a;
    bus.flush       = fl;
    bus.out_ready   = ordy;
    #5;
    acc = 1'b0;
    if (fl) begin
      rsv_v = 1'b0;
    end else if (v && bus.in_ready) begin
      acc = 1'b1;
      model_accept(ins, a);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [ADDR_W-1:0] a);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      step(1'b1, ins, a, 1'b0, 1'b1, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept, expected accept within 40 cycles");
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, '0, 1'b0, ordy, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    idle(1, 1'b1);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    q.delete();
    rsv_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_word", 32'({bus.out_valid, dut_word()}), 32'h0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
    end else begin
      exp_ir = (q.size() == 0) || (q.size() == 1 && !q[0].multi && bus.out_ready);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      if (bus.out_valid && q.size() > 0) chk("ctrl_word", 32'(dut_word()), 32'(q[0].w));
      if (bus.flush) q.delete();
      else if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          acc;
    logic [31:0] ins;
    logic [31:0] addr;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.mem_addr    = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LR then SC to the same granule succeeds; a repeated SC fails.
    send(ins_of(7'b0101111, 5'b00010), 32'h1000);
    send(ins_of(7'b0101111, 5'b00011), 32'h1002);
    send(ins_of(7'b0101111, 5'b00011), 32'h1000);
    drain();

    // An intervening store to the granule kills the reservation.
    send(ins_of(7'b0101111, 5'b00010), 32'h2000);
    send(ins_of(7'b0100011, 5'b00000), 32'h2003);
    send(ins_of(7'b0101111, 5'b00011), 32'h2000);
    drain();

    // AMOADD stalled by execute: read word holds and no new instruction enters.
    send(ins_of(7'b0101111, 5'b00000), 32'h3000);
    for (int i = 0; i < 3; i++) step(1'b1, ins_of(7'b0110011, 5'b0), 32'h0, 1'b0, 1'b0, acc);
    drain();

    // Back-to-back single-phase words.
    send(ins_of(7'b0110011, 5'b0), 32'h0);
    send(ins_of(7'b0010011, 5'b0), 32'h0);
    send(ins_of(7'b1100011, 5'b0), 32'h0);
    drain();

    // Flush during the read phase drops the write phase and the reservation.
    send(ins_of(7'b0101111, 5'b00010), 32'h4000);
    drain();
    send(ins_of(7'b0101111, 5'b00001), 32'h5000);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, acc);
    idle(2, 1'b1);
    send(ins_of(7'b0101111, 5'b00011), 32'h4000);
    drain();

    // Reset during the write phase, then an unknown opcode.
    send(ins_of(7'b0101111, 5'b00000), 32'h6000);
    idle(1, 1'b1);
    idle(1, 1'b0);
    do_reset();
    idle(1, 1'b1);
    send(ins_of(7'b1111111, 5'b0), 32'h0);
    drain();

    for (int i = 0; i < 400; i++) begin
      ins      = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 11)];
      if (ins[6:0] == 7'b0101111) ins[31:27] = f5_tab[$urandom_range(0, 6)];
      addr = 32'h1000 + 32'($urandom_range(0, 11));
      step($urandom_range(0, 3) != 0, ins, addr, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Registered, multi-cycle successor to the single-cycle control decoder. It accepts one instruction per handshake and decodes the opcode into the same control-signal set, then registers the result. AMO instructions are sequenced into separate memory read and write phases. An LR/SC reservation is tracked internally. It sits between fetch/decode and execute, and absorbs execute back-pressure through a valid/ready pair on each side.

## Interface
- ADDR_W, 32: width of the effective memory address.
- GRAIN_LSB, 2: log2 of the reservation granule in bytes; addresses are compared on bits [ADDR_W-1:GRAIN_LSB].
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  instruction and address valid.
- in_ready  out  1  block can take an instruction this cycle.
- instruction  in  32  full instruction word; opcode [6:0], funct3 [14:12], funct5 [31:27].
- mem_addr  in  ADDR_W  effective address for loads, stores and AMOs; sampled on accept.
- flush  in  1  discard the held instruction.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute consumes the word.
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  registered control bits.
- alu_op  out  3  LOAD/STORE 000, BRANCH 001, OP 010, JAL/JALR/LUI/AUIPC 011, AMO 100, OP-IMM 110, otherwise 111.
- amo_phase  out  2  00 none, 01 read phase, 10 write phase.
- sc_fail  out  1  SC failed; rd must receive 1.
- illegal  out  1  opcode matched no known class.

## Operation
- States: IDLE (no word held), HOLD (single-phase word held), AMO_RD, AMO_WR.
- in_ready = (state==IDLE) or (state==HOLD and out_ready); gives back-to-back throughput for single-phase words.
- Accept (in_valid and in_ready):
  - Non-AMO opcodes → HOLD, with control bits decoded as in the single-cycle decoder.
  - Opcode 0101111 → AMO path.
- LR (funct5 00010), single phase → HOLD:
  - mem_read=mem_to_reg=reg_write=alu_src=1; amo_phase=01.
  - Sets the reservation to mem_addr[ADDR_W-1:GRAIN_LSB] and marks it valid.
- SC (funct5 00011), single phase → HOLD:
  - Reservation valid and address matches: mem_write=1, alu_src=1, reg_write=1, sc_fail=0, amo_phase=10.
  - Otherwise: mem_write=0, reg_write=1, sc_fail=1, amo_phase=00.
  - The reservation is cleared in both cases.
- Other AMO funct5, two phases:
  - AMO_RD: mem_read=mem_to_reg=reg_write=alu_src=1, amo_phase=01.
  - On out_ready → AMO_WR: mem_write=alu_src=1, reg_write=0, amo_phase=10.
  - On out_ready → IDLE; in_ready stays 0 during both phases.
  - The reservation is cleared if the address matches.
- A store (0100011) whose granule matches a valid reservation clears the reservation on accept.
- HOLD and out_ready, with no new accept → IDLE.
- flush:
  - Forces IDLE and out_valid=0, and clears the reservation.
  - Overrides a same-cycle accept and out_ready.
  - A flushed AMO_RD never emits its write phase.
- Unknown opcode: illegal=1, alu_op=111, every other control bit 0. It is still handed over as a word.

## Timing
- Reset values: state IDLE, out_valid 0, all control bits 0, alu_op 000, amo_phase 00, sc_fail 0, illegal 0, reservation invalid.
- Latency: the control word appears on out_valid one cycle after accept.
- The word holds stable while out_valid=1 and out_ready=0.
- Throughput: 1 word/cycle for single-phase instructions; an AMO occupies 2 output handshakes minimum.
- If a store clears the reservation while an SC is being accepted, the SC fails. Each instruction is evaluated against the reservation state at the start of its accept cycle.
- Reset asserted mid-AMO returns to reset values immediately; no write phase is emitted.

## Structure
- Package ctrl_pkg holds:
  - Opcode localparams.
  - AMO funct5 constants.
  - alu_op encodings.
  - amo_phase encodings.
  - State enum.
  - Packed ctrl_word_t struct carrying the eleven output fields.
- Sub-module ctrl_decode is the combinational opcode-to-ctrl_word_t decoder for single-phase classes. ctrl_seq owns the FSM, output register and reservation.

## Test plan
- LR at 0x1000, then SC at 0x1002 → SC has mem_write=1, sc_fail=0, and the reservation clears. A second SC at 0x1000 → sc_fail=1, mem_write=0.
- LR at 0x2000, store to 0x2003, SC at 0x2000 → sc_fail=1.
- AMOADD (funct5 00000), out_ready low for 3 cycles → AMO_RD word holds, in_ready=0. Then 2 handshakes emit amo_phase 01 then 10, after which in_ready returns.
- Back-to-back ADD, ADDI, BEQ with out_ready=1 → out_valid every cycle with alu_op 010, 110, 001 in order.
- flush during AMO_RD → out_valid=0 next cycle, no amo_phase=10 word, and a subsequent SC fails.
- rst_n pulled low mid-AMO_WR, and opcode 1111111 after reset → all outputs at reset values, then illegal=1 with alu_op=111.
